// File: rtl/accum_warp_looper.sv
// accum_warp_looper: walks an accumulation range [beg,end) in warp-sized
// tiles, odometer order (dim VDIM-1 innermost). It emits one warp descriptor
// per tile over a ready/ack handshake and pulses blkdone_dval once the block
// is finished.

package TauCfg;
    localparam int unsigned WORK_BW = 16;
    localparam int unsigned VDIM    = 2;
    localparam int unsigned N_ICFG  = 15;
endpackage

module accum_warp_looper #(
    parameter int unsigned WBW  = TauCfg::WORK_BW,
    parameter int unsigned VDIM = TauCfg::VDIM,
    parameter int unsigned IDBW = $clog2(TauCfg::N_ICFG + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      src_rdy,
    output logic                      src_ack,
    input  logic [VDIM-1:0][WBW-1:0]  i_bofs,
    input  logic [VDIM-1:0][WBW-1:0]  i_aofs_beg,
    input  logic [VDIM-1:0][WBW-1:0]  i_aofs_end,
    input  logic [IDBW-1:0]           i_id_beg,
    input  logic [IDBW-1:0]           i_id_end,
    input  logic [VDIM-1:0][WBW-1:0]  i_wstep,
    output logic                      dst_rdy,
    input  logic                      dst_ack,
    output logic [VDIM-1:0][WBW-1:0]  o_bofs,
    output logic [VDIM-1:0][WBW-1:0]  o_wofs_beg,
    output logic [VDIM-1:0][WBW-1:0]  o_wofs_end,
    output logic [IDBW-1:0]           o_id_beg,
    output logic [IDBW-1:0]           o_id_end,
    output logic                      o_islast,
    output logic                      blkdone_dval
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e                    state_q;
    logic [VDIM-1:0][WBW-1:0]  bofs_q;
    logic [VDIM-1:0][WBW-1:0]  beg_q;
    logic [VDIM-1:0][WBW-1:0]  end_q;
    logic [VDIM-1:0][WBW-1:0]  cur_q;
    logic [VDIM-1:0][WBW-1:0]  wend_q;
    logic [IDBW-1:0]           id_beg_q;
    logic [IDBW-1:0]           id_end_q;
    logic                      last_q;
    logic                      dst_rdy_q;
    logic                      blkdone_q;

    logic [VDIM-1:0][WBW-1:0]  step_c;
    logic [VDIM-1:0][WBW-1:0]  nxt_cur_c;
    logic [VDIM-1:0][WBW-1:0]  ld_cur_c;
    logic [VDIM-1:0][WBW-1:0]  ld_end_c;
    logic [VDIM-1:0][WBW-1:0]  ld_wend_c;
    logic                      ld_last_c;
    logic                      any_empty_c;
    logic                      carry_c;
    logic [WBW:0]              adv_sum_c;
    logic [WBW:0]              ld_sum_c;

    // Requests are only acknowledged in IDLE and never while reset is held.
    assign src_ack = src_rdy && (state_q == S_IDLE) && !i_rst;

    assign dst_rdy      = dst_rdy_q;
    assign blkdone_dval = blkdone_q;
    assign o_bofs       = bofs_q;
    assign o_wofs_beg   = cur_q;
    assign o_wofs_end   = wend_q;
    assign o_id_beg     = id_beg_q;
    assign o_id_end     = id_end_q;
    assign o_islast     = last_q;

    // Effective per-dim step: a zero step behaves as a unit step.
    always_comb begin
        step_c = '0;
        for (int d = 0; d < int'(VDIM); d++) begin
            step_c[d] = (i_wstep[d] == '0) ? WBW'(1) : i_wstep[d];
        end
    end

    // Odometer advance of the cursor; sums are taken one bit wider so they never wrap.
    always_comb begin
        nxt_cur_c = cur_q;
        carry_c   = 1'b1;
        adv_sum_c = '0;
        for (int d = int'(VDIM) - 1; d >= 0; d--) begin
            adv_sum_c = {1'b0, cur_q[d]} + {1'b0, step_c[d]};
            if (carry_c) begin
                if (adv_sum_c >= {1'b0, end_q[d]}) begin
                    nxt_cur_c[d] = beg_q[d];
                end else begin
                    nxt_cur_c[d] = adv_sum_c[WBW-1:0];
                    carry_c      = 1'b0;
                end
            end
        end
    end

    // Descriptor for the cursor about to be loaded: clamped tile end and last flag.
    always_comb begin
        ld_cur_c    = (state_q == S_IDLE) ? i_aofs_beg : nxt_cur_c;
        ld_end_c    = (state_q == S_IDLE) ? i_aofs_end : end_q;
        ld_wend_c   = '0;
        ld_last_c   = 1'b1;
        ld_sum_c    = '0;
        any_empty_c = 1'b0;
        for (int d = 0; d < int'(VDIM); d++) begin
            ld_sum_c = {1'b0, ld_cur_c[d]} + {1'b0, step_c[d]};
            if (ld_sum_c >= {1'b0, ld_end_c[d]}) begin
                ld_wend_c[d] = ld_end_c[d];
            end else begin
                ld_wend_c[d] = ld_sum_c[WBW-1:0];
                ld_last_c    = 1'b0;
            end
            if (i_aofs_beg[d] >= i_aofs_end[d]) begin
                any_empty_c = 1'b1;
            end
        end
    end

    // Control FSM with registered descriptor outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            bofs_q    <= '0;
            beg_q     <= '0;
            end_q     <= '0;
            cur_q     <= '0;
            wend_q    <= '0;
            id_beg_q  <= '0;
            id_end_q  <= '0;
            last_q    <= 1'b0;
            dst_rdy_q <= 1'b0;
            blkdone_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (src_ack) begin
                        bofs_q   <= i_bofs;
                        beg_q    <= i_aofs_beg;
                        end_q    <= i_aofs_end;
                        id_beg_q <= i_id_beg;
                        id_end_q <= i_id_end;
                        if (any_empty_c) begin
                            state_q   <= S_FIN;
                            blkdone_q <= 1'b1;
                        end else begin
                            state_q   <= S_RUN;
                            dst_rdy_q <= 1'b1;
                            cur_q     <= ld_cur_c;
                            wend_q    <= ld_wend_c;
                            last_q    <= ld_last_c;
                        end
                    end
                end
                S_RUN: begin
                    if (dst_ack) begin
                        if (last_q) begin
                            state_q   <= S_FIN;
                            dst_rdy_q <= 1'b0;
                            blkdone_q <= 1'b1;
                            last_q    <= 1'b0;
                        end else begin
                            cur_q  <= ld_cur_c;
                            wend_q <= ld_wend_c;
                            last_q <= ld_last_c;
                        end
                    end
                end
                S_FIN: begin
                    state_q   <= S_IDLE;
                    blkdone_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    dst_rdy_q <= 1'b0;
                    blkdone_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/accum_warp_looper.md
ACCUM_WARP_LOOPER -- requirements
Module: accum_warp_looper

Interface
REQ-001 SHALL have parameter WBW, default TauCfg::WORK_BW, offset/step width.
REQ-002 SHALL have parameter VDIM, default TauCfg::VDIM, number of dimensions; dim VDIM-1 is innermost.
REQ-003 SHALL have parameter IDBW, default $clog2(TauCfg::N_ICFG+1), config-id width.
REQ-004 SHALL have port i_clk  in  1  clock; one clock domain only.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port src_rdy  in  1  abofs request valid.
REQ-007 SHALL have port src_ack  out  1  abofs request accepted.
REQ-008 SHALL have ports i_bofs, i_aofs_beg, i_aofs_end  in  WBW x VDIM each  block offset and accum range [beg,end).
REQ-009 SHALL have ports i_id_beg, i_id_end  in  IDBW each  config-id range, carried through.
REQ-010 SHALL have port i_wstep  in  WBW x VDIM  per-dim warp step, static while not idle.
REQ-011 SHALL have port dst_rdy  out  1  warp descriptor valid.
REQ-012 SHALL have port dst_ack  in  1  warp descriptor consumed; asserted only while dst_rdy.
REQ-013 SHALL have ports o_bofs, o_wofs_beg, o_wofs_end  out  WBW x VDIM each  block offset, warp range.
REQ-014 SHALL have ports o_id_beg, o_id_end  out  IDBW each  captured id range.
REQ-015 SHALL have port o_islast  out  1  current descriptor is last of block.
REQ-016 SHALL have port blkdone_dval  out  1  one-cycle block-complete pulse.

Function
REQ-017 SHALL implement states IDLE, RUN, FIN.
REQ-018 IDLE: src_ack SHALL equal src_rdy; on src_ack all i_* (except i_wstep) SHALL be captured into registers.
REQ-019 On capture, if any dim has i_aofs_beg >= i_aofs_end (unsigned), SHALL go to FIN without issuing descriptors; else go to RUN with cursor = i_aofs_beg.
REQ-020 RUN: dst_rdy SHALL be 1; src_ack SHALL be 0; outputs SHALL hold stable until dst_ack.
REQ-021 o_wofs_beg[d] SHALL equal cursor[d]; o_wofs_end[d] SHALL equal min(cursor[d]+step[d], aofs_end[d]), sum computed at WBW+1 bits (no wrap).
REQ-022 step[d] SHALL be i_wstep[d], with 0 treated as 1.
REQ-023 On dst_ack, cursor SHALL advance odometer-style: innermost dim += step; a dim whose next value (WBW+1 bits) >= aofs_end resets to aofs_beg and carries to the next outer dim.
REQ-024 o_islast SHALL be 1 iff every dim would carry; dst_ack with o_islast SHALL move RUN->FIN.
REQ-025 FIN: SHALL last exactly one cycle with blkdone_dval=1, dst_rdy=0, src_ack=0, then return to IDLE.
REQ-026 blkdone_dval SHALL be 0 in all other states; a new request SHALL be accepted no earlier than the cycle after FIN.
REQ-027 Descriptor count per block SHALL be product over d of ceil((end-beg)/step); latency capture->first dst_rdy is one cycle.
REQ-028 o_bofs, o_id_beg, o_id_end SHALL equal the captured values for every descriptor of the block.

Reset
REQ-029 i_rst SHALL immediately force IDLE, all outputs and registers to 0, including mid-RUN; the in-flight block is dropped without blkdone_dval.
REQ-030 First capture after reset release SHALL occur no earlier than the first rising i_clk edge with i_rst low.

Verification
REQ-031 VDIM=2, beg{0,0} end{4,6} step{2,4}, dst_ack always 1 -> 4 descriptors (0,0)-(2,4), (0,4)-(2,6), (2,0)-(4,4), (2,4)-(4,6); o_islast only on 4th; blkdone_dval one cycle after.
REQ-032 beg{3,0} end{3,8} -> src_ack, no dst_rdy, blkdone_dval the next cycle, IDLE after.
REQ-033 Random dst_ack back-pressure on REQ-031 stimulus -> same sequence, outputs stable while dst_rdy & !dst_ack.
REQ-034 step{0,0}, beg{0,0} end{1,2} -> 2 descriptors with unit ranges; end near 2^WBW-1 with large step -> o_wofs_end clamps, no wrap.
REQ-035 i_rst asserted after 2nd descriptor of REQ-031 -> outputs 0 asynchronously, no blkdone_dval; subsequent request runs fully.
REQ-036 src_rdy held high across blocks -> src_ack pulses only in IDLE, never in RUN/FIN; id and bofs fields track each block.
